// File: rtl/exec_pkg.sv
// Shared execute-stage definitions: opcode encodings, the integer unit FSM
// states and the iterative mul/div operating mode.
package exec_pkg;

   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_MUL = 4'b0011;
   localparam logic [3:0] OP_DIV = 4'b0100;
   localparam logic [3:0] OP_MOD = 4'b0101;
   localparam logic [3:0] OP_SHL = 4'b0110;
   localparam logic [3:0] OP_SHR = 4'b0111;
   localparam logic [3:0] OP_AND = 4'b1000;
   localparam logic [3:0] OP_OR  = 4'b1001;
   localparam logic [3:0] OP_XOR = 4'b1010;
   localparam logic [3:0] OP_NEG = 4'b1011;
   localparam logic [3:0] OP_NOT = 4'b1100;
   localparam logic [3:0] OP_LDI = 4'b1101;
   localparam logic [3:0] OP_JL  = 4'b1110;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_HOLD = 2'd3
   } state_e;

   typedef enum logic {
      MD_MUL = 1'b0,
      MD_DIV = 1'b1
   } md_mode_e;

endpackage

// File: rtl/mc_muldiv_iter.sv
// One-bit-per-step unsigned shift-add multiplier and restoring divider sharing
// one accumulator and two operand shift registers; exposes next-state values.
module mc_muldiv_iter
   import exec_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             start_i,
   input  md_mode_e         mode_i,
   input  logic             step_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] acc_nxt_o,
   output logic [WIDTH-1:0] quo_nxt_o
);

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH:0]   trial;

   // mul: opa = multiplier (shifts right), opb = multiplicand (shifts left)
   // div: opa = dividend shifting out / quotient shifting in, opb = divisor
   always_comb begin
      acc_d = acc_q;
      opa_d = opa_q;
      opb_d = opb_q;
      trial = {acc_q, opa_q[WIDTH-1]} - {1'b0, opb_q};
      if (start_i) begin
         acc_d = '0;
         opa_d = a_i;
         opb_d = b_i;
      end else if (step_i) begin
         if (mode_i == MD_MUL) begin
            if (opa_q[0]) acc_d = acc_q + opb_q;
            opa_d = opa_q >> 1;
            opb_d = opb_q << 1;
         end else if (!trial[WIDTH]) begin
            acc_d = trial[WIDTH-1:0];
            opa_d = {opa_q[WIDTH-2:0], 1'b1};
         end else begin
            acc_d = {acc_q[WIDTH-2:0], opa_q[WIDTH-1]};
            opa_d = {opa_q[WIDTH-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk_i) begin
      acc_q <= acc_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
   end

   assign acc_nxt_o = acc_d;
   assign quo_nxt_o = opa_d;

endmodule

// File: rtl/mc_int_unit.sv
// Multi-cycle integer execute unit: single-cycle ALU ops plus iterative
// mul/div/mod, with a valid/ready handshake on both request and result.
module mc_int_unit
   import exec_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             div_zero,
   output logic             busy
);

   localparam int SH_W = $clog2(WIDTH);

   function automatic logic [WIDTH-1:0] single_op(input logic [3:0] opc,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
      logic [WIDTH-1:0] r;
      case (opc)
         OP_ADD:  r = x + y;
         OP_SUB:  r = x - y;
         OP_SHL:  r = x << y[SH_W-1:0];
         OP_SHR:  r = x >> y[SH_W-1:0];
         OP_AND:  r = x & y;
         OP_OR:   r = x | y;
         OP_XOR:  r = x ^ y;
         OP_NEG:  r = '0 - x;
         OP_NOT:  r = ~x;
         OP_LDI:  r = y;
         OP_JL:   r = x;
         default: r = '0;
      endcase
      return r;
   endfunction

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             div_zero_q, div_zero_d;
   logic             is_mod_q, is_mod_d;
   logic             accept, cnt_last;
   logic             md_start, md_step;
   md_mode_e         md_mode;
   logic [WIDTH-1:0] acc_nxt, quo_nxt;

   assign in_ready  = (state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready);
   assign accept    = in_valid && in_ready;
   assign cnt_last  = (cnt_q == CNT_W'(WIDTH - 1));
   assign out_valid = (state_q == S_HOLD);
   assign busy      = (state_q == S_MUL) || (state_q == S_DIV);
   assign result    = result_q;
   assign div_zero  = div_zero_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      result_d   = result_q;
      div_zero_d = div_zero_q;
      is_mod_d   = is_mod_q;
      md_start   = 1'b0;
      md_step    = 1'b0;
      md_mode    = MD_MUL;
      case (state_q)
         S_MUL: begin
            md_step = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_last) begin
               state_d    = S_HOLD;
               result_d   = acc_nxt;
               div_zero_d = 1'b0;
            end
         end
         S_DIV: begin
            md_step = 1'b1;
            md_mode = MD_DIV;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_last) begin
               state_d    = S_HOLD;
               result_d   = is_mod_q ? acc_nxt : quo_nxt;
               div_zero_d = 1'b0;
            end
         end
         S_HOLD: begin
            if (out_ready && !in_valid) state_d = S_IDLE;
         end
         default: ;
      endcase
      // Accept only occurs from IDLE/HOLD, so it never collides with a step.
      if (accept) begin
         cnt_d      = '0;
         div_zero_d = 1'b0;
         is_mod_d   = (op == OP_MOD);
         case (op)
            OP_MUL: begin
               md_start = 1'b1;
               state_d  = S_MUL;
            end
            OP_DIV, OP_MOD: begin
               if (b == '0) begin
                  state_d    = S_HOLD;
                  div_zero_d = 1'b1;
                  result_d   = (op == OP_MOD) ? a : '1;
               end else begin
                  md_start = 1'b1;
                  state_d  = S_DIV;
               end
            end
            default: begin
               state_d  = S_HOLD;
               result_d = single_op(op, a, b);
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         result_q   <= '0;
         div_zero_q <= 1'b0;
         is_mod_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         result_q   <= result_d;
         div_zero_q <= div_zero_d;
         is_mod_q   <= is_mod_d;
      end
   end

   mc_muldiv_iter #(
      .WIDTH(WIDTH)
   ) u_iter (
      .clk_i    (clk),
      .start_i  (md_start),
      .mode_i   (md_mode),
      .step_i   (md_step),
      .a_i      (a),
      .b_i      (b),
      .acc_nxt_o(acc_nxt),
      .quo_nxt_o(quo_nxt)
   );

endmodule

// File: tb/tb_mc_int_unit.sv
// Directed plus randomized bench for mc_int_unit (WIDTH=32) against an
// arithmetic reference model of results, div_zero flag and latency.
module tb_mc_int_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         div_zero;
   logic         busy;

   int n_checks = 0;
   int n_pass   = 0;

   mc_int_unit #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .op       (op),
      .a        (a),
      .b        (b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result   (result),
      .div_zero (div_zero),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Reference model: {div_zero, result} from plain arithmetic.
   function automatic logic [W:0] model(input logic [3:0] o, input logic [W-1:0] x,
                                        input logic [W-1:0] y);
      logic [63:0] p;
      case (o)
         4'd1:  return {1'b0, x + y};
         4'd2:  return {1'b0, x - y};
         4'd3:  begin p = 64'(x) * 64'(y); return {1'b0, p[W-1:0]}; end
         4'd4:  return (y == 0) ? {1'b1, {W{1'b1}}} : {1'b0, x / y};
         4'd5:  return (y == 0) ? {1'b1, x} : {1'b0, x % y};
         4'd6:  return {1'b0, x << (y % W)};
         4'd7:  return {1'b0, x >> (y % W)};
         4'd8:  return {1'b0, x & y};
         4'd9:  return {1'b0, x | y};
         4'd10: return {1'b0, x ^ y};
         4'd11: return {1'b0, 32'd0 - x};
         4'd12: return {1'b0, ~x};
         4'd13: return {1'b0, y};
         4'd14: return {1'b0, x};
         default: return '0;
      endcase
   endfunction

   function automatic bit is_iter(input logic [3:0] o, input logic [W-1:0] y);
      return (o == 4'd3) || ((o == 4'd4 || o == 4'd5) && y != 0);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Issue one request from IDLE, measure latency/busy, optionally stall the result.
   task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input int stall);
      logic [W:0]   e;
      logic [W-1:0] first;
      int lat, bsy;
      e = model(o, x, y);
      @(negedge clk);
      op = o; a = x; b = y; in_valid = 1'b1; out_ready = (stall == 0);
      chk({tag, ".in_ready"}, in_ready, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0; bsy = 0;
      while (1) begin
         @(negedge clk);
         lat++;
         if (busy) bsy++;
         if (out_valid || lat > 100) break;
      end
      chk({tag, ".latency"}, lat, is_iter(o, y) ? W + 1 : 1);
      chk({tag, ".busy_cycles"}, bsy, is_iter(o, y) ? W : 0);
      chk({tag, ".result"}, result, e[W-1:0]);
      chk({tag, ".div_zero"}, div_zero, e[W]);
      first = result;
      for (int k = 0; k < stall; k++) begin
         @(posedge clk); @(negedge clk);
         chk({tag, ".stall_result"}, result, e[W-1:0]);
         chk({tag, ".stall_valid"}, out_valid, 1);
         chk({tag, ".stall_in_ready"}, in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      chk({tag, ".drained"}, out_valid, 0);
   endtask

   initial begin
      logic [W:0]   e1, e2;
      logic [W-1:0] ra, rb, sub_res;
      logic [3:0]   ro;
      int seen;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset.out_valid", out_valid, 0);
      chk("reset.busy", busy, 0);
      chk("reset.in_ready", in_ready, 1);
      chk("reset.result", result, 0);
      chk("reset.div_zero", div_zero, 0);
      rst = 1'b0;

      run_op("add", 4'd1, 32'd5, 32'd7, 0);
      run_op("mul", 4'd3, 32'h0001_0003, 32'h0000_0010, 0);
      run_op("div", 4'd4, 32'd100, 32'd7, 0);
      run_op("mod", 4'd5, 32'd100, 32'd7, 0);
      run_op("div0", 4'd4, 32'd9, 32'd0, 0);
      run_op("mod0", 4'd5, 32'd9, 32'd0, 1);
      run_op("op0", 4'd0, 32'hDEAD_BEEF, 32'h1234_5678, 0);
      run_op("op15", 4'd15, 32'hDEAD_BEEF, 32'h1234_5678, 0);

      // Back-to-back single-cycle ops, then a 3-cycle result stall.
      ra = $urandom; rb = $urandom;
      e1 = model(4'd10, ra, rb);
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; op = 4'd10; a = ra; b = rb;
      @(posedge clk); @(negedge clk);
      chk("b2b.xor_valid", out_valid, 1);
      chk("b2b.xor_result", result, e1[W-1:0]);
      chk("b2b.xor_in_ready", in_ready, 1);
      op = 4'd6; a = 32'd1; b = 32'd33;
      @(posedge clk); @(negedge clk);
      chk("b2b.shl_valid", out_valid, 1);
      chk("b2b.shl_result", result, 32'd2);
      op = 4'd2; a = 32'd3; b = 32'd5;
      sub_res = 32'hFFFF_FFFE;
      @(posedge clk); @(negedge clk);
      chk("b2b.sub_result", result, sub_res);
      ra = $urandom; rb = $urandom;
      e2 = model(4'd8, ra, rb);
      op = 4'd8; a = ra; b = rb; out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); @(negedge clk);
         chk("stall.result", result, sub_res);
         chk("stall.valid", out_valid, 1);
         chk("stall.in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("b2b.and_result", result, e2[W-1:0]);
      in_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("b2b.drained", out_valid, 0);

      // Reset wins over a simultaneous accept.
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b1; op = 4'd1; a = 32'd1; b = 32'd2;
      @(posedge clk);
      #1 rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("rst_accept.out_valid", out_valid, 0);
      chk("rst_accept.in_ready", in_ready, 1);
      @(posedge clk); @(negedge clk);
      chk("rst_accept.out_valid2", out_valid, 0);

      // Reset in the middle of a division.
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; op = 4'd4; a = $urandom; b = $urandom | 32'd1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      chk("middiv.busy", busy, 1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("middiv.out_valid", out_valid, 0);
      chk("middiv.busy_after", busy, 0);
      chk("middiv.in_ready", in_ready, 1);
      chk("middiv.result", result, 0);
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("middiv.no_emit", seen, 0);
      run_op("add_after_rst", 4'd1, $urandom, $urandom, 0);

      // Randomized ops against the reference model.
      for (int i = 0; i < 25; i++) begin
         ro = 4'($urandom_range(0, 15));
         ra = $urandom;
         rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, $urandom_range(0, 2));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
